// File: rtl/rv_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv_mem_pkg
// Shared types and constants for the unified instruction/data memory port
// arbiter (mem_port_arbiter).
//   owner_e     : which requester owns the in-flight transaction
//   arb_state_e : arbiter FSM state
//   MEM_LAT_MIN / MEM_LAT_MAX : legal range of the memory read latency
// ---------------------------------------------------------------------------
package rv_mem_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_WAIT = 1'b1
   } arb_state_e;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

endpackage : rv_mem_pkg

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch (IF) request port, the load/store (LS) request port and
// the memory macro command/response port of mem_port_arbiter.
//   slave  : the arbiter's view (takes requests, drives grants/responses and
//            the memory command, takes mem_rdata)
//   master : the requesters' and memory's view (the opposite directions)
//
// Handshake: a requester raises *_req with its address/data and holds all of
// them stable until *_gnt is seen high in the same cycle; the transaction is
// accepted on the rising edge where req and gnt are both high. Dropping req
// before gnt withdraws the request. *_rvalid is a single-cycle pulse with no
// back-pressure; *_rdata is meaningful only while *_rvalid is high and is
// zero otherwise.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch port
   logic                if_req;
   logic [ADDR_W-1:0]   if_addr;
   logic                if_gnt;
   logic                if_rvalid;
   logic [DATA_W-1:0]   if_rdata;
   // load/store port
   logic                ls_req;
   logic                ls_we;
   logic [DATA_W/8-1:0] ls_be;
   logic [ADDR_W-1:0]   ls_addr;
   logic [DATA_W-1:0]   ls_wdata;
   logic                ls_gnt;
   logic                ls_rvalid;
   logic [DATA_W-1:0]   ls_rdata;
   // memory macro port
   logic                mem_req;
   logic                mem_we;
   logic [DATA_W/8-1:0] mem_be;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Purely combinational winner selection for mem_port_arbiter.
//   if_req_i  : fetch request
//   ls_req_i  : load/store request
//   free_i    : the memory port can accept a command this cycle
//   starve_i  : fetch has lost too often; it wins a tie
//   win_o     : winning requester (meaningful only when valid_o is high)
//   valid_o   : a requester wins this cycle
// LS wins a tie unless starve_i is set.
// ---------------------------------------------------------------------------
module mem_arb_pick
   import rv_mem_pkg::*;
(
   input  logic   if_req_i,
   input  logic   ls_req_i,
   input  logic   free_i,
   input  logic   starve_i,
   output owner_e win_o,
   output logic   valid_o
);

   always_comb begin
      win_o   = OWN_IF;
      valid_o = 1'b0;
      if (free_i) begin
         if (if_req_i && (starve_i || !ls_req_i)) begin
            win_o   = OWN_IF;
            valid_o = 1'b1;
         end else if (ls_req_i) begin
            win_o   = OWN_LS;
            valid_o = 1'b1;
         end
      end
   end

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port unified I/D memory between the fetch unit (IF) and
// the load/store unit (LS). One transaction is in flight at a time; the
// fixed read latency MEM_LAT is tracked and the response is routed back to
// the requester that issued it.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : mem_port_arbiter_if.slave (IF port, LS port, memory port)
//   dbg_state_o : current FSM state
//   dbg_owner_o : owner of the current/last transaction
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..4), STARVE_MAX (1..7).
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let IF win a tie after
// STARVE_MAX consecutive LS wins against a pending IF request. Without it LS
// has strict priority.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus,
   output arb_state_e         dbg_state_o,
   output owner_e             dbg_owner_o
);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
      $error("mem_port_arbiter: MEM_LAT must be in 1..4");
   end
   if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_starve_chk
      $error("mem_port_arbiter: STARVE_MAX must be in 1..7");
   end

   localparam logic [2:0] LAT3 = 3'(MEM_LAT);

   arb_state_e  state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic        wr_q, wr_d;          // in-flight LS transaction is a write

   logic        resp;
   logic        free;
   logic        starve_flag;
   owner_e      pick_win;
   logic        pick_valid;

   assign resp = (state_q == ARB_WAIT) && (lat_cnt_q == LAT3);
   // rst_n gates free so that no grant rises while reset is held; grants
   // become possible in the same cycle reset is released.
   assign free = rst_n && ((state_q == ARB_IDLE) || resp);

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [2:0] STARVE3 = 3'(STARVE_MAX);
   logic [2:0] starve_cnt_q, starve_cnt_d;

   assign starve_flag = (starve_cnt_q == STARVE3);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.if_req || bus.if_gnt) begin
         starve_cnt_d = 3'd0;
      end else if (bus.ls_gnt && (starve_cnt_q < STARVE3)) begin
         starve_cnt_d = starve_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= 3'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign starve_flag = 1'b0;
`endif

   mem_arb_pick u_pick (
      .if_req_i (bus.if_req),
      .ls_req_i (bus.ls_req),
      .free_i   (free),
      .starve_i (starve_flag),
      .win_o    (pick_win),
      .valid_o  (pick_valid)
   );

   // Grants and memory command: winner's fields muxed out, zero otherwise.
   always_comb begin
      bus.if_gnt    = 1'b0;
      bus.ls_gnt    = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (pick_valid) begin
         bus.mem_req = 1'b1;
         if (pick_win == OWN_IF) begin
            bus.if_gnt   = 1'b1;
            bus.mem_addr = bus.if_addr;
            bus.mem_be   = '1;
         end else begin
            bus.ls_gnt    = 1'b1;
            bus.mem_we    = bus.ls_we;
            bus.mem_be    = bus.ls_be;
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
         end
      end
   end

   // Response routing: only the registered owner sees rvalid/rdata.
   always_comb begin
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.ls_rvalid = 1'b0;
      bus.ls_rdata  = '0;
      if (resp) begin
         if (owner_q == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
         end else begin
            bus.ls_rvalid = 1'b1;
            bus.ls_rdata  = wr_q ? '0 : bus.mem_rdata;
         end
      end
   end

   // Next state: a new accept overrides the return to idle, so a response
   // and a new grant can share a cycle.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      lat_cnt_d = lat_cnt_q;
      wr_d      = wr_q;
      if ((state_q == ARB_WAIT) && (lat_cnt_q < LAT3)) begin
         lat_cnt_d = lat_cnt_q + 3'd1;
      end
      if (resp) begin
         state_d = ARB_IDLE;
      end
      if (pick_valid) begin
         state_d   = ARB_WAIT;
         owner_d   = pick_win;
         lat_cnt_d = 3'd1;
         wr_d      = (pick_win == OWN_LS) && bus.ls_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         owner_q   <= OWN_IF;
         lat_cnt_q <= 3'd0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_cnt_q <= lat_cnt_d;
         wr_q      <= wr_d;
      end
   end

   assign dbg_state_o = state_q;
   assign dbg_owner_o = owner_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Bench for mem_port_arbiter with two instances: u_lat1 (MEM_LAT=1, bus1)
// and u_lat2 (MEM_LAT=2, bus2). Each has a small memory model; a monitor per
// instance checks the memory command on every accept, pushes the expected
// response (data and cycle) into a queue and pops it when rvalid appears.
// Compile with +define+MEM_ARB_STARVE_GUARD_EN to exercise the guard build.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import rv_mem_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc  = 0;
   int   vecs = 0;
   int   errs = 0;

   // expected responses: index = bus*2 + (0: IF, 1: LS)
   logic [31:0] exp_q [4][$];
   int          exp_cyc_q [4][$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
   arb_state_e st1, st2;
   owner_e     own1, own2;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .dbg_state_o(st1), .dbg_owner_o(own1));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .dbg_state_o(st2), .dbg_owner_o(own2));

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = i[7:0];
      if (i == 64) return 32'h0050_0093;
      return {8'hA5, b, 8'h5A, ~b};
   endfunction

   // ---------------- memory models ----------------
   logic [31:0] mem1 [256];
   logic [31:0] mem2 [256];
   logic [31:0] p1a, p2a, p2b;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
         p1a <= 32'hBAD0_BAD0;
      end else if (bus1.mem_req && !bus1.mem_we) begin
         p1a <= mem1[bus1.mem_addr[9:2]];
      end else begin
         if (bus1.mem_req)
            for (int k = 0; k < 4; k++)
               if (bus1.mem_be[k]) mem1[bus1.mem_addr[9:2]][8*k +: 8] <= bus1.mem_wdata[8*k +: 8];
         p1a <= 32'hBAD0_BAD0;
      end
   end
   assign bus1.mem_rdata = p1a;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem2[i] <= init_word(i);
         p2a <= 32'hBAD0_BAD0;
      end else if (bus2.mem_req && !bus2.mem_we) begin
         p2a <= mem2[bus2.mem_addr[9:2]];
      end else begin
         if (bus2.mem_req)
            for (int k = 0; k < 4; k++)
               if (bus2.mem_be[k]) mem2[bus2.mem_addr[9:2]][8*k +: 8] <= bus2.mem_wdata[8*k +: 8];
         p2a <= 32'hBAD0_BAD0;
      end
      p2b <= p2a;
   end
   assign bus2.mem_rdata = p2b;

   // ---------------- scoreboard monitor ----------------
   task automatic mon(input int b, input int lat,
      input logic if_req, input logic [31:0] if_addr, input logic if_gnt,
      input logic if_rvalid, input logic [31:0] if_rdata,
      input logic ls_req, input logic ls_we, input logic [3:0] ls_be,
      input logic [31:0] ls_addr, input logic [31:0] ls_wdata,
      input logic ls_gnt, input logic ls_rvalid, input logic [31:0] ls_rdata,
      input logic mem_req, input logic mem_we, input logic [3:0] mem_be,
      input logic [31:0] mem_addr, input logic [31:0] mem_wdata,
      input logic [31:0] if_exp, input logic [31:0] ls_exp);
      logic        rv [2];
      logic [31:0] rd [2];
      string       nm [2];
      if (!rst_n) begin
         for (int r = 0; r < 2; r++) begin
            exp_q[b*2+r].delete();
            exp_cyc_q[b*2+r].delete();
         end
         return;
      end
      // command side
      vecs++;
      if ((if_gnt && !if_req) || (ls_gnt && !ls_req) || (if_gnt && ls_gnt)) begin
         errs++;
         $display("FAIL bus%0d gnt_legal: got if_gnt=%b ls_gnt=%b expected at most one, only with req (if_req=%b ls_req=%b)",
                  b, if_gnt, ls_gnt, if_req, ls_req);
      end else if (if_gnt) begin
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== if_addr || mem_wdata !== 32'h0) begin
            errs++;
            $display("FAIL bus%0d if_cmd: got req=%b we=%b be=%h addr=%h wd=%h expected 1 0 f %h 0",
                     b, mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_addr);
         end
         exp_q[b*2].push_back(if_exp);
         exp_cyc_q[b*2].push_back(cyc + lat);
      end else if (ls_gnt) begin
         if (mem_req !== 1'b1 || mem_we !== ls_we || mem_be !== ls_be || mem_addr !== ls_addr || mem_wdata !== ls_wdata) begin
            errs++;
            $display("FAIL bus%0d ls_cmd: got req=%b we=%b be=%h addr=%h wd=%h expected 1 %b %h %h %h",
                     b, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ls_we, ls_be, ls_addr, ls_wdata);
         end
         exp_q[b*2+1].push_back(ls_exp);
         exp_cyc_q[b*2+1].push_back(cyc + lat);
      end else if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         errs++;
         $display("FAIL bus%0d idle_cmd: got req=%b we=%b be=%h addr=%h wd=%h expected all 0",
                  b, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      // response side
      rv[0] = if_rvalid; rd[0] = if_rdata; nm[0] = "if";
      rv[1] = ls_rvalid; rd[1] = ls_rdata; nm[1] = "ls";
      for (int r = 0; r < 2; r++) begin
         int q = b*2 + r;
         vecs++;
         if (rv[r] === 1'b1) begin
            if (exp_q[q].size() == 0) begin
               errs++;
               $display("FAIL bus%0d %s_unexpected_rvalid: got 1 expected 0 (cycle %0d)", b, nm[r], cyc);
            end else begin
               logic [31:0] ed;
               int          ec;
               ed = exp_q[q].pop_front();
               ec = exp_cyc_q[q].pop_front();
               if (rd[r] !== ed || cyc != ec) begin
                  errs++;
                  $display("FAIL bus%0d %s_resp: got data %h at cycle %0d expected %h at cycle %0d",
                           b, nm[r], rd[r], cyc, ed, ec);
               end
            end
         end else if (exp_cyc_q[q].size() != 0 && exp_cyc_q[q][0] <= cyc) begin
            errs++;
            $display("FAIL bus%0d %s_missing_rvalid: got %b expected 1 at cycle %0d", b, nm[r], rv[r], cyc);
            void'(exp_q[q].pop_front());
            void'(exp_cyc_q[q].pop_front());
         end else if (rv[r] !== 1'b0 || rd[r] !== 32'h0) begin
            errs++;
            $display("FAIL bus%0d %s_idle_resp: got rvalid=%b rdata=%h expected 0 0", b, nm[r], rv[r], rd[r]);
         end
      end
   endtask

   always @(negedge clk)
      mon(0, 1, bus1.if_req, bus1.if_addr, bus1.if_gnt, bus1.if_rvalid, bus1.if_rdata,
          bus1.ls_req, bus1.ls_we, bus1.ls_be, bus1.ls_addr, bus1.ls_wdata,
          bus1.ls_gnt, bus1.ls_rvalid, bus1.ls_rdata,
          bus1.mem_req, bus1.mem_we, bus1.mem_be, bus1.mem_addr, bus1.mem_wdata,
          mem1[bus1.if_addr[9:2]], bus1.ls_we ? 32'h0 : mem1[bus1.ls_addr[9:2]]);

   always @(negedge clk)
      mon(1, 2, bus2.if_req, bus2.if_addr, bus2.if_gnt, bus2.if_rvalid, bus2.if_rdata,
          bus2.ls_req, bus2.ls_we, bus2.ls_be, bus2.ls_addr, bus2.ls_wdata,
          bus2.ls_gnt, bus2.ls_rvalid, bus2.ls_rdata,
          bus2.mem_req, bus2.mem_we, bus2.mem_be, bus2.mem_addr, bus2.mem_wdata,
          mem2[bus2.if_addr[9:2]], bus2.ls_we ? 32'h0 : mem2[bus2.ls_addr[9:2]]);

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus1.if_req = 1'b0; bus1.if_addr = '0;
      bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_be = '0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
      bus2.if_req = 1'b0; bus2.if_addr = '0;
      bus2.ls_req = 1'b0; bus2.ls_we = 1'b0; bus2.ls_be = '0; bus2.ls_addr = '0; bus2.ls_wdata = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      // IF request held during reset must not be granted
      bus1.if_req = 1'b1; bus1.if_addr = 32'h100;
      @(negedge clk);
      vecs++;
      if (bus2.if_gnt !== 1'b0 || bus2.ls_gnt !== 1'b0 || bus2.if_rvalid !== 1'b0 || bus2.ls_rvalid !== 1'b0 ||
          bus2.if_rdata !== 32'h0 || bus2.ls_rdata !== 32'h0 || bus2.mem_req !== 1'b0 || bus2.mem_addr !== 32'h0 ||
          st2 !== ARB_IDLE || own2 !== OWN_IF) begin
         errs++;
         $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b mem_req=%b state=%0d owner=%0d expected all 0, IDLE, IF",
                  bus2.if_gnt, bus2.ls_gnt, bus2.if_rvalid, bus2.ls_rvalid, bus2.mem_req, st2, own2);
      end
      vecs++;
      if (bus1.if_gnt !== 1'b0 || bus1.mem_req !== 1'b0) begin
         errs++;
         $display("FAIL reset_gnt_masked: got if_gnt=%b mem_req=%b expected 0 0", bus1.if_gnt, bus1.mem_req);
      end
      // release reset; bus1 IF granted at once, bus2 starts an LS read
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus2.ls_req = 1'b1; bus2.ls_addr = 32'h40;
      @(negedge clk);
      vecs++;
      if (bus1.if_gnt !== 1'b1) begin
         errs++;
         $display("FAIL post_reset_if_gnt: got %b expected 1", bus1.if_gnt);
      end
      vecs++;
      if (bus2.ls_gnt !== 1'b1) begin
         errs++;
         $display("FAIL mid_txn_ls_gnt: got %b expected 1", bus2.ls_gnt);
      end
      // reset for one cycle before the LS response is due
      tick();
      idle_all();
      rst_n = 1'b0;
      @(negedge clk);
      vecs++;
      if (bus2.ls_rvalid !== 1'b0 || st2 !== ARB_IDLE) begin
         errs++;
         $display("FAIL mid_txn_reset: got ls_rvalid=%b state=%0d expected 0 IDLE", bus2.ls_rvalid, st2);
      end
      tick();
      rst_n = 1'b1;
      bus2.if_req = 1'b1; bus2.if_addr = 32'h100;
      @(negedge clk);
      vecs++;
      if (bus2.if_gnt !== 1'b1 || bus2.ls_rvalid !== 1'b0) begin
         errs++;
         $display("FAIL reset_release_gnt: got if_gnt=%b ls_rvalid=%b expected 1 0", bus2.if_gnt, bus2.ls_rvalid);
      end
      tick();
      bus2.if_req = 1'b0; bus2.if_addr = '0;
      repeat (4) tick();
   endtask

   task automatic test_single_if();
      tick();
      bus2.if_req = 1'b1; bus2.if_addr = 32'h100;
      @(negedge clk);
      vecs++;
      if (bus2.if_gnt !== 1'b1 || bus2.mem_addr !== 32'h100 || bus2.mem_req !== 1'b1) begin
         errs++;
         $display("FAIL single_if_c0: got gnt=%b mem_req=%b mem_addr=%h expected 1 1 00000100",
                  bus2.if_gnt, bus2.mem_req, bus2.mem_addr);
      end
      tick();
      bus2.if_req = 1'b0; bus2.if_addr = '0;
      @(negedge clk);
      vecs++;
      if (bus2.if_rvalid !== 1'b0 || st2 !== ARB_WAIT) begin
         errs++;
         $display("FAIL single_if_c1: got rvalid=%b state=%0d expected 0 WAIT", bus2.if_rvalid, st2);
      end
      tick();
      @(negedge clk);
      vecs++;
      if (bus2.if_rvalid !== 1'b1 || bus2.if_rdata !== 32'h0050_0093) begin
         errs++;
         $display("FAIL single_if_c2: got rvalid=%b rdata=%h expected 1 00500093", bus2.if_rvalid, bus2.if_rdata);
      end
      tick();
      @(negedge clk);
      vecs++;
      if (st2 !== ARB_IDLE || bus2.if_rvalid !== 1'b0) begin
         errs++;
         $display("FAIL single_if_c3: got state=%0d rvalid=%b expected IDLE 0", st2, bus2.if_rvalid);
      end
      repeat (2) tick();
   endtask

   task automatic test_simultaneous();
      tick();
      bus1.if_req = 1'b1; bus1.if_addr = 32'h200;
      bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_be = 4'b0011;
      bus1.ls_addr = 32'h2000; bus1.ls_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      vecs++;
      if (bus1.ls_gnt !== 1'b1 || bus1.if_gnt !== 1'b0 || bus1.mem_we !== 1'b1 || bus1.mem_be !== 4'b0011) begin
         errs++;
         $display("FAIL simul_c0: got ls_gnt=%b if_gnt=%b we=%b be=%h expected 1 0 1 3",
                  bus1.ls_gnt, bus1.if_gnt, bus1.mem_we, bus1.mem_be);
      end
      tick();
      bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_be = '0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
      @(negedge clk);
      vecs++;
      if (bus1.ls_rvalid !== 1'b1 || bus1.ls_rdata !== 32'h0 || bus1.if_gnt !== 1'b1 || bus1.mem_addr !== 32'h200) begin
         errs++;
         $display("FAIL simul_c1: got ls_rvalid=%b ls_rdata=%h if_gnt=%b mem_addr=%h expected 1 0 1 00000200",
                  bus1.ls_rvalid, bus1.ls_rdata, bus1.if_gnt, bus1.mem_addr);
      end
      tick();
      bus1.if_req = 1'b0; bus1.if_addr = '0;
      @(negedge clk);
      vecs++;
      if (bus1.if_rvalid !== 1'b1 || bus1.if_rdata !== init_word(128) || bus1.ls_rvalid !== 1'b0) begin
         errs++;
         $display("FAIL simul_c2: got if_rvalid=%b if_rdata=%h ls_rvalid=%b expected 1 %h 0",
                  bus1.if_rvalid, bus1.if_rdata, bus1.ls_rvalid, init_word(128));
      end
      repeat (2) tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      logic [31:0] w0;
      addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18; addrs[3] = 32'h0;
      w0 = init_word(0);
      tick();
      for (int i = 0; i < 4; i++) begin
         bus1.ls_req  = (i < 3);
         bus1.ls_addr = addrs[i];
         @(negedge clk);
         vecs++;
         if (bus1.ls_gnt !== (i < 3)) begin
            errs++;
            $display("FAIL b2b_gnt_%0d: got %b expected %b", i, bus1.ls_gnt, (i < 3));
         end
         if (i > 0) begin
            vecs++;
            if (bus1.ls_rvalid !== 1'b1 || bus1.ls_rdata !== init_word(3 + i)) begin
               errs++;
               $display("FAIL b2b_resp_%0d: got rvalid=%b rdata=%h expected 1 %h",
                        i, bus1.ls_rvalid, bus1.ls_rdata, init_word(3 + i));
            end
         end
         tick();
      end
      // read back the earlier byte-masked write to 0x2000
      bus1.ls_req = 1'b1; bus1.ls_addr = 32'h2000;
      tick();
      bus1.ls_req = 1'b0; bus1.ls_addr = '0;
      @(negedge clk);
      vecs++;
      if (bus1.ls_rvalid !== 1'b1 || bus1.ls_rdata !== {w0[31:16], 16'hBEEF}) begin
         errs++;
         $display("FAIL byte_write_readback: got rvalid=%b rdata=%h expected 1 %h",
                  bus1.ls_rvalid, bus1.ls_rdata, {w0[31:16], 16'hBEEF});
      end
      repeat (2) tick();
   endtask

   task automatic test_starvation();
      logic exp_if;
      tick();
      bus1.if_req = 1'b1; bus1.if_addr = 32'h300;
      bus1.ls_req = 1'b1; bus1.ls_addr = 32'h40 + 32'($urandom_range(0, 15) * 4);
      for (int i = 0; i < 20; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         exp_if = ((i % 5) == 4);
`else
         exp_if = 1'b0;
`endif
         @(negedge clk);
         vecs++;
         if (bus1.if_gnt !== exp_if || bus1.ls_gnt !== !exp_if) begin
            errs++;
            $display("FAIL starve_cycle_%0d: got if_gnt=%b ls_gnt=%b expected %b %b",
                     i, bus1.if_gnt, bus1.ls_gnt, exp_if, !exp_if);
         end
         tick();
      end
      idle_all();
      repeat (3) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_all();
      repeat (2) @(posedge clk);
      test_reset();
      test_single_if();
      test_simultaneous();
      test_back_to_back();
      test_starvation();
      repeat (4) tick();
      @(negedge clk);
      for (int q = 0; q < 4; q++) begin
         vecs++;
         if (exp_q[q].size() != 0) begin
            errs++;
            $display("FAIL drain_q%0d: got %0d pending responses expected 0", q, exp_q[q].size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory of the RV32I core between the fetch unit (IF) and the load/store unit (LS). It accepts at most one memory transaction at a time. It tracks the fixed memory read latency and routes each response back to the requester that issued it. Requesters stall while their grant is low. The block sits between the fetch/LSU request ports and the memory macro.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from an accepted `mem_req` to valid `mem_rdata`; legal range 1..4
- `STARVE_MAX`, 4, consecutive LS wins allowed against a pending IF request; used only with the guard macro
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `if_req`  in  1  IF read request
- `if_addr`  in  ADDR_W  IF address
- `if_gnt`  out  1  IF request accepted this cycle
- `if_rvalid`  out  1  IF response valid
- `if_rdata`  out  DATA_W  IF read data
- `ls_req`  in  1  LS request
- `ls_we`  in  1  LS write enable
- `ls_be`  in  DATA_W/8  LS byte enables
- `ls_addr`  in  ADDR_W  LS address
- `ls_wdata`  in  DATA_W  LS write data
- `ls_gnt`  out  1  LS request accepted this cycle
- `ls_rvalid`  out  1  LS response valid (read data, or write completion)
- `ls_rdata`  out  DATA_W  LS read data
- `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory command
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- **States:** ARB_IDLE and ARB_WAIT. Registers: `owner` (IF or LS), `lat_cnt` (3 bits), `starve_cnt` (3 bits).
- **Free condition:** `free` = (state == ARB_IDLE) or (state == ARB_WAIT and `lat_cnt` == MEM_LAT).
- **Grant:** when `free`, at most one `*_gnt` rises, combinationally from the `*_req` inputs. With no guard, LS has priority. A transaction is accepted when req and gnt are both high.
- **Memory command:** on accept, `mem_req` is 1 and the `mem_*` fields are muxed from the winner. IF commands force `mem_we`=0 and `mem_be`=all ones. With no accept, `mem_req`=0 and the other `mem_*` outputs are 0.
- **Registers on accept:** `owner` is set to the winner, `lat_cnt` is set to 1, and the next state is ARB_WAIT.
- **Counting in ARB_WAIT:** `lat_cnt` increments each cycle while it is below MEM_LAT.
- **Response cycle:** this is the cycle with state ARB_WAIT and `lat_cnt` == MEM_LAT.
  - The owner's `rvalid` is 1 and its `rdata` = `mem_rdata`. For an LS write, `ls_rdata` = 0.
  - The non-owner's `rdata` is 0.
  - If no new request is accepted in the same cycle, the next state is ARB_IDLE.
- **Requester rules:** requesters hold req and their address/data stable until gnt. A request dropped before gnt is legal and is not recorded.
- **Simultaneous events:** a response and a new grant may occur in the same cycle, to the same or the other requester. The new owner is registered on that edge.
- **Reset mid-transaction:** the in-flight transaction is discarded. No `rvalid` is issued for it, and any late `mem_rdata` is ignored.

## Timing
- **Reset values:** all outputs 0; state ARB_IDLE, `owner` = IF, `lat_cnt` = 0, `starve_cnt` = 0.
- **Grant latency:** 0 cycles (combinational) when free.
- **Response latency:** `rvalid` arrives exactly MEM_LAT cycles after the accept edge.
- **Throughput:** one transaction per MEM_LAT cycles. With MEM_LAT = 1 this is one per cycle.
- **No combinational path** from `mem_rdata` to any `gnt`.

## Configuration
- **`MEM_ARB_STARVE_GUARD_EN` defined:**
  - `starve_cnt` increments on each LS accept that occurs while `if_req` is high, saturating at STARVE_MAX.
  - It clears on an IF accept or in any cycle with `if_req` low.
  - When `starve_cnt` == STARVE_MAX and both requesters are requesting, IF wins.
- **Not defined:** strict LS priority. `starve_cnt` is absent, and STARVE_MAX is ignored.

## Structure
- **Package `rv_mem_pkg`:** owner enum (OWN_IF, OWN_LS), state enum (ARB_IDLE, ARB_WAIT), and the MEM_LAT_MIN = 1 / MEM_LAT_MAX = 4 constants.
- **Sub-module `mem_arb_pick`:** purely combinational winner selection (req pair, `free`, starve flag → winner, valid). Instantiated once.
- **Parameter check:** an elaboration-time check rejects MEM_LAT outside 1..4.

## Test plan
- **Reset mid-transaction (MEM_LAT=2):** LS read accepted, `rst_n` low for 1 cycle before response → no `ls_rvalid`. First post-reset IF request is granted in the cycle `rst_n` rises.
- **Single IF read (MEM_LAT=2):** `if_req`, `if_addr`=0x100; memory returns 0x00500093 → `if_gnt` in cycle 0, `mem_addr`=0x100, `if_rvalid` with `if_rdata`=0x00500093 in cycle 2, state ARB_IDLE in cycle 3.
- **Simultaneous requests, no guard (MEM_LAT=1):** `if_req` and `ls_req` (LS write, `ls_be`=4'b0011, `ls_addr`=0x2000) both high → `ls_gnt` first, `ls_rvalid` and `if_gnt` together in the next cycle, `if_rvalid` one cycle later.
- **Back-to-back reads (MEM_LAT=1):** LS reads 0x10, 0x14, 0x18 held continuously → `ls_gnt` every cycle, three consecutive `ls_rvalid` pulses in order.
- **Starvation guard (macro defined, STARVE_MAX=4):** `if_req` and `ls_req` held high → 4 LS grants, then 1 IF grant, then LS again.
- **Starvation without macro:** same stimulus → `if_gnt` stays 0 for 20 cycles.
